opll_bus_writer: RTL and testbench

//  Host-side initiator for the OPLL (YM2413-style) register write bus. It queues
//  (register, value) write requests and plays each one out as two bus cycles:
//  an address write (A0=0), then a data write (A0=1). Each cycle is paced by the

---
 rtl/opll_bus_writer.sv | 175 +++++++++++++++++
 tb/tb_opll_bus_writer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opll_bus_writer.sv
// OPLL register write initiator: FIFO of (reg,value) requests played out as
// paced address/data bus cycles on D[7:0], A0 and an active-high WR strobe.
module opll_bus_writer #(
    parameter int DEPTH     = 4,
    parameter int WR_PULSE  = 4,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_reg_data,
    output logic [7:0] o_D,
    output logic       o_A0,
    output logic       o_WR,
    output logic       o_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int MAX_A = (WR_PULSE > ADDR_WAIT) ? WR_PULSE : ADDR_WAIT;
    localparam int MAX_N = (MAX_A > DATA_WAIT) ? MAX_A : DATA_WAIT;
    localparam int CW    = $clog2(MAX_N + 1);

    localparam logic [CW-1:0]  WP_LD    = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0]  AW_LD    = CW'(ADDR_WAIT - 1);
    localparam logic [CW-1:0]  DW_LD    = CW'(DATA_WAIT - 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        A_SET,
        A_WR,
        A_WAIT,
        D_SET,
        D_WR,
        D_WAIT
    } state_t;

    logic [15:0]      mem_q [DEPTH];
    logic [15:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;

    state_t           state_q, state_d;
    logic [CW-1:0]    tmr_q, tmr_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       d_q, d_d;
    logic             a0_q, a0_d;
    logic             wr_q, wr_d;

    logic full, empty, push, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = i_valid && !full;
    assign pop   = (state_q == IDLE) && !empty;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = {i_reg_addr, i_reg_data};
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Bus outputs are computed from the next state so they leave a flop.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        data_d  = data_q;
        d_d     = d_q;
        a0_d    = a0_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = A_SET;
                    d_d     = mem_q[rptr_q][15:8];
                    data_d  = mem_q[rptr_q][7:0];
                    a0_d    = 1'b0;
                end
            end
            A_SET: begin
                state_d = A_WR;
                tmr_d   = WP_LD;
            end
            A_WR: begin
                if (tmr_q == '0) begin
                    state_d = A_WAIT;
                    tmr_d   = AW_LD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            A_WAIT: begin
                if (tmr_q == '0) begin
                    state_d = D_SET;
                    d_d     = data_q;
                    a0_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            D_SET: begin
                state_d = D_WR;
                tmr_d   = WP_LD;
            end
            D_WR: begin
                if (tmr_q == '0) begin
                    state_d = D_WAIT;
                    tmr_d   = DW_LD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            D_WAIT: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_d = (state_d == A_WR) || (state_d == D_WR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            tmr_q   <= '0;
            data_q  <= '0;
            d_q     <= '0;
            a0_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            data_q  <= data_d;
            d_q     <= d_d;
            a0_q    <= a0_d;
            wr_q    <= wr_d;
        end
    end

    assign o_D     = d_q;
    assign o_A0    = a0_q;
    assign o_WR    = wr_q;
    assign o_ready = !full;
    assign o_busy  = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_opll_bus_writer.sv
// Bench for opll_bus_writer: timeline model of the bus per write, literal
// timing checks, random traffic, async reset and a default-parameter instance.
module tb_opll_bus_writer;

    localparam int P   = 2;
    localparam int AWT = 3;
    localparam int DWT = 5;
    localparam int DEP = 4;
    localparam int T   = 3 + 2 * P + AWT + DWT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       valid = 1'b0;
    logic [7:0] addr  = '0;
    logic [7:0] data  = '0;
    logic       ready, a0, wr, busy;
    logic [7:0] dbus;

    logic       dvalid = 1'b0;
    logic [7:0] daddr  = '0;
    logic [7:0] ddata  = '0;
    logic       dready, da0, dwr, dbusy;
    logic [7:0] ddbus;

    opll_bus_writer #(
        .DEPTH(DEP), .WR_PULSE(P), .ADDR_WAIT(AWT), .DATA_WAIT(DWT)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(valid), .o_ready(ready),
        .i_reg_addr(addr), .i_reg_data(data), .o_D(dbus), .o_A0(a0),
        .o_WR(wr), .o_busy(busy)
    );

    opll_bus_writer dut_def (
        .clk(clk), .rst(rst), .i_valid(dvalid), .o_ready(dready),
        .i_reg_addr(daddr), .i_reg_data(ddata), .o_D(ddbus), .o_A0(da0),
        .o_WR(dwr), .o_busy(dbusy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model: a write popped at edge e occupies cycles k=1..T-1 after e.
    logic [15:0] mq[$];
    bit          m_act = 0;
    int          m_k   = 0;
    logic [15:0] m_cur = '0;
    logic [7:0]  m_D   = '0;
    bit          m_A0  = 0;

    initial begin
        bit acc, pp;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_act = 0;
                m_k   = 0;
                m_D   = '0;
                m_A0  = 0;
            end else begin
                acc = valid && (mq.size() < DEP);
                pp  = !m_act && (mq.size() > 0);
                if (m_act) begin
                    if (m_k == T - 1) m_act = 0;
                    else m_k++;
                end
                if (pp) begin
                    m_cur = mq.pop_front();
                    m_act = 1;
                    m_k   = 1;
                end
                if (acc) mq.push_back({addr, data});
                if (m_act && m_k == 1) begin
                    m_D  = m_cur[15:8];
                    m_A0 = 0;
                end
                if (m_act && m_k == 2 + P + AWT) begin
                    m_D  = m_cur[7:0];
                    m_A0 = 1;
                end
            end
        end
    end

    function automatic bit m_wr();
        return m_act && ((m_k >= 2 && m_k <= 1 + P) ||
               (m_k >= 3 + P + AWT && m_k <= 2 + 2 * P + AWT));
    endfunction

    bit         log_en = 0;
    int         rise_cyc[$];
    logic [7:0] rise_d[$];
    bit         pv = 0;
    logic [7:0] p_D;
    logic       p_A0, p_WR;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0;
            end else begin
                tests++;
                if (dbus !== m_D || a0 !== m_A0 || wr !== m_wr() ||
                    busy !== (m_act || mq.size() > 0) ||
                    ready !== (mq.size() < DEP)) begin
                    fails++;
                    $display("FAIL model cyc %0d: got D=%h A0=%b WR=%b busy=%b rdy=%b exp D=%h A0=%b WR=%b busy=%b rdy=%b",
                             cyc, dbus, a0, wr, busy, ready, m_D, m_A0,
                             m_wr(), m_act || mq.size() > 0,
                             mq.size() < DEP);
                end
                if (pv && wr) begin
                    tests++;
                    if (dbus !== p_D || a0 !== p_A0) begin
                        fails++;
                        $display("FAIL setup_hold cyc %0d: D=%h A0=%b prev D=%h A0=%b",
                                 cyc, dbus, a0, p_D, p_A0);
                    end
                end
                if (log_en && pv && wr && !p_WR && !a0) begin
                    rise_cyc.push_back(cyc);
                    rise_d.push_back(dbus);
                end
                pv   = 1;
                p_D  = dbus;
                p_A0 = a0;
                p_WR = wr;
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        bit r;
        int to;
        valid = 1'b1;
        addr  = a;
        data  = d;
        to    = 0;
        forever begin
            r = ready;
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            to++;
            if (to > 200) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic drain();
        int to;
        to = 0;
        while ((m_act || mq.size() > 0) && to < 500) begin
            @(negedge clk);
            to++;
        end
        chk("drain_timeout", (to >= 500), 0);
        repeat (2) @(negedge clk);
    endtask

    int ar[$], af[$], df[$], a0r[$];
    int bfall;

    initial begin
        bit pw, pa, pb;
        int to;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_D", dbus, 8'h00);
        chk("rst_A0", a0, 0);
        chk("rst_WR", wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single write, literal timeline relative to the push edge
        valid = 1'b1;
        addr  = 8'h10;
        data  = 8'h55;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t1_wr_%0d", j), wr,
                (j == 2 || j == 3 || j == 8 || j == 9));
            if (j == 1 || j == 4 || j == 6) begin
                chk($sformatf("t1_d_%0d", j), {a0, dbus}, 9'h010);
            end
            if (j == 7 || j == 10 || j == 15) begin
                chk($sformatf("t1_d_%0d", j), {a0, dbus}, 9'h155);
            end
            if (j == 14 || j == 15) begin
                chk($sformatf("t1_busy_%0d", j), busy, (j == 14));
            end
        end
        @(negedge clk);

        // six writes with valid held high
        log_en = 1;
        for (int i = 0; i < 6; i++) begin
            push(8'h20 + 8'(i), 8'hA0 + 8'(i));
            if (i == 4) chk("t2_ready_low", ready, 0);
        end
        valid = 1'b0;
        drain();
        log_en = 0;
        chk("t2_count", rise_cyc.size(), 6);
        if (rise_cyc.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("t2_order_%0d", i), rise_d[i], 8'h20 + 8'(i));
                if (i > 0) begin
                    chk($sformatf("t2_gap_%0d", i),
                        rise_cyc[i] - rise_cyc[i-1], 15);
                end
            end
        end

        // random traffic
        for (int c = 0; c < 500; c++) begin
            valid = ($urandom_range(0, 3) == 0);
            addr  = 8'($urandom);
            data  = 8'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
        drain();

        // async reset during the data strobe
        push(8'h44, 8'h99);
        push(8'h45, 8'h9A);
        valid = 1'b0;
        to = 0;
        while (!(m_act && m_k == 3 + P + AWT) && to < 100) begin
            @(negedge clk);
            to++;
        end
        chk("t4_reach_dwr", wr, 1);
        #2 rst = 1'b1;
        #1;
        chk("t4_wr", wr, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ready", ready, 1);
        chk("t4_D", dbus, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        valid = 1'b1;
        addr  = 8'h30;
        data  = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            #1;
            if (j == 1) chk("t4_aset", {a0, dbus, wr}, {1'b0, 8'h30, 1'b0});
            if (j == 2) chk("t4_awr", wr, 1);
            if (j == 7) chk("t4_dset", {a0, dbus, wr}, {1'b1, 8'h0F, 1'b0});
            if (j == 8) chk("t4_dwr", wr, 1);
        end
        drain();

        // default-parameter instance: two back-to-back writes
        @(negedge clk);
        dvalid = 1'b1;
        daddr  = 8'h0E;
        ddata  = 8'h20;
        @(posedge clk);
        @(negedge clk);
        ddata = 8'h21;
        @(posedge clk);
        @(negedge clk);
        dvalid = 1'b0;
        pw = 0;
        pa = 0;
        pb = 1;
        bfall = -1;
        for (int c = 0; c < 400 && bfall < 0; c++) begin
            @(posedge clk);
            #1;
            if (dwr && !pw && !da0) ar.push_back(cyc);
            if (!dwr && pw && !da0) af.push_back(cyc);
            if (!dwr && pw && da0) df.push_back(cyc);
            if (da0 && !pa) a0r.push_back(cyc);
            if (!dbusy && pb) bfall = cyc;
            pw = dwr;
            pa = da0;
            pb = dbusy;
        end
        chk("t5_events", {8'(ar.size()), 8'(af.size()), 8'(df.size()),
                          8'(a0r.size())}, 32'h02020202);
        chk("t5_bfall_seen", (bfall >= 0), 1);
        if (ar.size() == 2 && af.size() == 2 && df.size() == 2 &&
            a0r.size() == 2) begin
            chk("t5_pulse", af[0] - ar[0], 4);
            chk("t5_addr_wait", a0r[0] - af[0], 12);
            chk("t5_period", ar[1] - ar[0], 107);
            chk("t5_data_wait", bfall - df[1], 84);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
